// File: rtl/unidade_controle_exp3.sv
// unidade_controle_exp3: Moore control unit that clears the experiment
// counter, then steps it one value at a time with a programmable dwell,
// stopping on a comparator hit (ACERTOU) or at terminal count (ESGOTOU).
module unidade_controle_exp3 #(
  parameter int PASSO_CICLOS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausa,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       conta,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic [3:0] db_estado
);

  // Dwell timer is just wide enough to reach PASSO_CICLOS-1; it never wraps.
  localparam int TW = (PASSO_CICLOS > 1) ? $clog2(PASSO_CICLOS) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(PASSO_CICLOS - 1);

  // State codes double as the hex debug display value.
  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    COMPARA    = 4'h2,
    ESPERA     = 4'h3,
    PROXIMO    = 4'h4,
    ACERTOU    = 4'hA,
    ESGOTOU    = 4'hE
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_next;
  logic            w_fim_espera;

  // Dwell ends on the cycle the timer sits at its last value and is not paused.
  assign w_fim_espera = (r_timer == TIMER_MAX) && !pausa;

  // State and dwell timer registers; reset forces INICIAL from any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_timer  <= '0;
    end else begin
      r_estado <= w_prox;
      r_timer  <= w_timer_next;
    end
  end

  // Timer is held at zero outside ESPERA so every dwell starts from 0.
  always_comb begin
    w_timer_next = '0;
    if (r_estado == ESPERA) begin
      if (!pausa && (r_timer != TIMER_MAX)) begin
        w_timer_next = r_timer + 1'b1;
      end else begin
        w_timer_next = r_timer;
      end
    end
  end

  // Next-state logic and Moore output decode of the current state.
  always_comb begin
    w_prox    = INICIAL;
    zera      = 1'b0;
    conta     = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    db_estado = 4'h0;
    case (r_estado)
      INICIAL: begin
        db_estado = 4'h0;
        w_prox    = iniciar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        db_estado = 4'h1;
        zera      = 1'b1;
        w_prox    = COMPARA;
      end
      COMPARA: begin
        db_estado = 4'h2;
        // A match wins over terminal count, so a hit at 15 is still a hit.
        if (igual)     w_prox = ACERTOU;
        else if (fim)  w_prox = ESGOTOU;
        else           w_prox = ESPERA;
      end
      ESPERA: begin
        db_estado = 4'h3;
        w_prox    = w_fim_espera ? PROXIMO : ESPERA;
      end
      PROXIMO: begin
        db_estado = 4'h4;
        conta     = 1'b1;
        w_prox    = COMPARA;
      end
      ACERTOU: begin
        db_estado = 4'hA;
        pronto    = 1'b1;
        acertou   = 1'b1;
        w_prox    = iniciar ? PREPARACAO : ACERTOU;
      end
      ESGOTOU: begin
        db_estado = 4'hE;
        pronto    = 1'b1;
        errou     = 1'b1;
        w_prox    = iniciar ? PREPARACAO : ESGOTOU;
      end
      default: begin
        // Unreachable codes recover to idle with every output low.
        w_prox = INICIAL;
      end
    endcase
  end

endmodule
